// File: rtl/robo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : robo_pkg
// Description : Shared types and constants for the move sequencer.
// Revision    : 1.0
// ============================================================================
package robo_pkg;

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        SAMPLE = 3'd1,
        OFFER  = 3'd2,
        FWD    = 3'd3,
        ROT    = 3'd4
    } state_t;

    localparam logic [1:0] HEADING_N = 2'd0;
    localparam logic [1:0] HEADING_E = 2'd1;
    localparam logic [1:0] HEADING_S = 2'd2;
    localparam logic [1:0] HEADING_W = 2'd3;

    localparam logic FWD_DIR = 1'b1;
    localparam logic REV_DIR = 1'b0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/robo_move_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : robo_move_sequencer_if
// Description : Sensor-snapshot offer and command handshake bundle.
// Revision    : 1.0
// ============================================================================
interface robo_move_sequencer_if;
    logic sens_valid;
    logic sens_head;
    logic sens_left;
    logic cmd_valid;
    logic cmd_ready;
    logic cmd_front;
    logic cmd_rotate;

    // master = decision logic, slave = move sequencer
    modport master (
        output cmd_valid, cmd_front, cmd_rotate,
        input  sens_valid, sens_head, sens_left, cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_front, cmd_rotate,
        output sens_valid, sens_head, sens_left, cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/robo_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : robo_tick_gen
// Description : Free-running prescaler emitting a one-clock motion tick.
// Revision    : 1.0
// ============================================================================
module robo_tick_gen #(
    parameter int TICK_DIV = 7
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/robo_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : robo_move_sequencer
// Description : Settle/sample/offer/move sequencer between wall-follow logic
//               and the motor drivers; tracks heading and forward steps.
// Revision    : 1.0
// ============================================================================
module robo_move_sequencer
    import robo_pkg::*;
#(
    parameter int TICK_DIV     = 7,
    parameter int FWD_TICKS    = 4,
    parameter int ROT_TICKS    = 3,
    parameter int SETTLE_TICKS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        head,
    input  logic                        left,
    robo_move_sequencer_if.slave        ctrl,
    output logic                        motor_l_en,
    output logic                        motor_l_dir,
    output logic                        motor_r_en,
    output logic                        motor_r_dir,
    output logic                        busy,
    output logic [1:0]                  heading,
    output logic [15:0]                 step_count,
    output logic                        bump
);
    localparam int TW = 8;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_TICKS - 1);
    localparam logic [TW-1:0] FWD_LAST    = TW'(FWD_TICKS - 1);
    localparam logic [TW-1:0] ROT_LAST    = TW'(ROT_TICKS - 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          tick;
    logic          head_s1;
    logic          head_sync;
    logic          left_s1;
    logic          left_sync;
    logic          fwd_done;
    logic          fwd_abort;
    logic          rot_done;
    logic          blocked;

    robo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_s1   <= 1'b0;
            head_sync <= 1'b0;
            left_s1   <= 1'b0;
            left_sync <= 1'b0;
        end else begin
            head_s1   <= head;
            head_sync <= head_s1;
            left_s1   <= left;
            left_sync <= left_s1;
        end
    end

    always_comb begin
        state_next = state;
        fwd_done   = 1'b0;
        fwd_abort  = 1'b0;
        rot_done   = 1'b0;
        blocked    = 1'b0;
        case (state)
            SETTLE: begin
                if (tick && (timer == SETTLE_LAST)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = OFFER;
            end
            OFFER: begin
                if (ctrl.cmd_valid && ctrl.cmd_ready) begin
                    if (ctrl.cmd_rotate) begin
                        state_next = ROT;
                    end else if (ctrl.cmd_front) begin
                        // Decision is made against the offered snapshot, not the live sensor
                        if (ctrl.sens_head) begin
                            blocked    = 1'b1;
                            state_next = SETTLE;
                        end else begin
                            state_next = FWD;
                        end
                    end else begin
                        state_next = SAMPLE;
                    end
                end
            end
            FWD: begin
                if (head_sync) begin
                    fwd_abort  = 1'b1;
                    state_next = SETTLE;
                end else if (tick && (timer == FWD_LAST)) begin
                    fwd_done   = 1'b1;
                    state_next = SETTLE;
                end
            end
            ROT: begin
                if (tick && (timer == ROT_LAST)) begin
                    rot_done   = 1'b1;
                    state_next = SETTLE;
                end
            end
            default: begin
                state_next = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (tick) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Handshake flags track the next state so they coincide with OFFER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl.sens_valid <= 1'b0;
            ctrl.cmd_ready  <= 1'b0;
            ctrl.sens_head  <= 1'b0;
            ctrl.sens_left  <= 1'b0;
            busy            <= 1'b1;
            bump            <= 1'b0;
        end else begin
            ctrl.sens_valid <= (state_next == OFFER);
            ctrl.cmd_ready  <= (state_next == OFFER);
            busy            <= (state_next != OFFER);
            bump            <= blocked | fwd_abort;
            if (state == SAMPLE) begin
                ctrl.sens_head <= head_sync;
                ctrl.sens_left <= left_sync;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heading    <= HEADING_N;
            step_count <= '0;
        end else begin
            if (fwd_done) begin
                step_count <= sat_inc16(step_count);
            end
            if (rot_done) begin
                heading <= heading + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motor_l_en  <= 1'b0;
            motor_l_dir <= REV_DIR;
            motor_r_en  <= 1'b0;
            motor_r_dir <= REV_DIR;
        end else begin
            motor_l_en  <= (state == FWD) || (state == ROT);
            motor_r_en  <= (state == FWD) || (state == ROT);
            motor_l_dir <= ((state == FWD) || (state == ROT)) ? FWD_DIR : REV_DIR;
            motor_r_dir <= (state == FWD) ? FWD_DIR : REV_DIR;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_robo_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_robo_move_sequencer
// Description : Directed scoreboard bench for robo_move_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_robo_move_sequencer;
    import robo_pkg::*;

    typedef struct {
        string       tag;
        int          fwd_lo;
        int          fwd_hi;
        int          rot_lo;
        int          rot_hi;
        int          bumps;
        logic [15:0] step;
        logic [1:0]  hdg;
        logic        s_head;
        logic        s_left;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        head = 1'b0;
    logic        left = 1'b0;
    logic        motor_l_en;
    logic        motor_l_dir;
    logic        motor_r_en;
    logic        motor_r_dir;
    logic        busy;
    logic [1:0]  heading;
    logic [15:0] step_count;
    logic        bump;

    int checks = 0;
    int errors = 0;
    int fwd_clks = 0;
    int rot_clks = 0;
    int bump_cnt = 0;
    exp_t exp_q[$];

    robo_move_sequencer_if ctrl ();

    robo_move_sequencer #(
        .TICK_DIV     (7),
        .FWD_TICKS    (4),
        .ROT_TICKS    (3),
        .SETTLE_TICKS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .head        (head),
        .left        (left),
        .ctrl        (ctrl),
        .motor_l_en  (motor_l_en),
        .motor_l_dir (motor_l_dir),
        .motor_r_en  (motor_r_en),
        .motor_r_dir (motor_r_dir),
        .busy        (busy),
        .heading     (heading),
        .step_count  (step_count),
        .bump        (bump)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (motor_l_en && motor_r_en && motor_l_dir && motor_r_dir) fwd_clks++;
        if (motor_l_en && motor_r_en && motor_l_dir && !motor_r_dir) rot_clks++;
        if (bump) bump_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic exp_t mk(input string tag, input int flo, input int fhi,
                                input int rlo, input int rhi, input int bumps,
                                input logic [15:0] step, input logic [1:0] hdg,
                                input logic sh, input logic sl);
        exp_t e;
        e.tag = tag; e.fwd_lo = flo; e.fwd_hi = fhi; e.rot_lo = rlo; e.rot_hi = rhi;
        e.bumps = bumps; e.step = step; e.hdg = hdg; e.s_head = sh; e.s_left = sl;
        return e;
    endfunction

    task automatic wait_offer(input string tag);
        int n;
        n = 0;
        while (!ctrl.sens_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_offer"}, ctrl.sens_valid, 1'b1);
    endtask

    task automatic issue(input string tag, input logic front, input logic rot);
        fwd_clks = 0; rot_clks = 0; bump_cnt = 0;
        ctrl.cmd_valid  = 1'b1;
        ctrl.cmd_front  = front;
        ctrl.cmd_rotate = rot;
        @(posedge clk); #1;
        ctrl.cmd_valid  = 1'b0;
        ctrl.cmd_front  = 1'b0;
        ctrl.cmd_rotate = 1'b0;
        check({tag, "_valid_drop"}, {ctrl.sens_valid, ctrl.cmd_ready}, 2'b00);
    endtask

    task automatic finish_cmd();
        exp_t e;
        e = exp_q.pop_front();
        wait_offer(e.tag);
        check_range({e.tag, "_fwd_clks"}, fwd_clks, e.fwd_lo, e.fwd_hi);
        check_range({e.tag, "_rot_clks"}, rot_clks, e.rot_lo, e.rot_hi);
        check({e.tag, "_bumps"}, bump_cnt, e.bumps);
        check({e.tag, "_step"}, step_count, e.step);
        check({e.tag, "_heading"}, heading, e.hdg);
        check({e.tag, "_snap"}, {ctrl.sens_head, ctrl.sens_left}, {e.s_head, e.s_left});
        check({e.tag, "_idle"}, {busy, motor_l_en, motor_r_en}, 3'b000);
    endtask

    initial begin
        int n;
        ctrl.cmd_valid  = 1'b0;
        ctrl.cmd_front  = 1'b0;
        ctrl.cmd_rotate = 1'b0;

        // Reset state, no clock edge needed
        #12;
        check("rst_motors", {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir}, 4'b0000);
        check("rst_hs", {ctrl.sens_valid, ctrl.cmd_ready, bump, busy}, 4'b0001);
        check("rst_heading", heading, HEADING_N);
        check("rst_step", step_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!ctrl.sens_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_range("first_offer_latency", n, 1, 18);
        check("first_snap", {ctrl.sens_head, ctrl.sens_left}, 2'b00);

        exp_q.push_back(mk("fwd1", 22, 28, 0, 0, 0, 16'd1, HEADING_N, 1'b0, 1'b0));
        issue("fwd1", 1'b1, 1'b0);
        finish_cmd();

        exp_q.push_back(mk("rot1", 0, 0, 15, 21, 0, 16'd1, HEADING_E, 1'b0, 1'b0));
        issue("rot1", 1'b1, 1'b1);
        finish_cmd();
        exp_q.push_back(mk("rot2", 0, 0, 15, 21, 0, 16'd1, HEADING_S, 1'b0, 1'b0));
        issue("rot2", 1'b0, 1'b1);
        finish_cmd();
        exp_q.push_back(mk("rot3", 0, 0, 15, 21, 0, 16'd1, HEADING_W, 1'b0, 1'b0));
        issue("rot3", 1'b1, 1'b1);
        finish_cmd();
        exp_q.push_back(mk("rot4", 0, 0, 15, 21, 0, 16'd1, HEADING_N, 1'b0, 1'b0));
        issue("rot4", 1'b0, 1'b1);
        finish_cmd();

        head = 1'b1; left = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(mk("resample_wall", 0, 0, 0, 0, 0, 16'd1, HEADING_N, 1'b1, 1'b1));
        issue("resample_wall", 1'b0, 1'b0);
        finish_cmd();

        exp_q.push_back(mk("blocked", 0, 0, 0, 0, 1, 16'd1, HEADING_N, 1'b1, 1'b1));
        issue("blocked", 1'b1, 1'b0);
        finish_cmd();

        head = 1'b0; left = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(mk("resample_clear", 0, 0, 0, 0, 0, 16'd1, HEADING_N, 1'b0, 1'b0));
        issue("resample_clear", 1'b0, 1'b0);
        finish_cmd();

        // Wall appears mid-move
        exp_q.push_back(mk("abort", 9, 13, 0, 0, 1, 16'd1, HEADING_N, 1'b0, 1'b0));
        issue("abort", 1'b1, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        head = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_motor_off", {motor_l_en, motor_r_en}, 2'b00);
        head = 1'b0;
        finish_cmd();

        force dut.step_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.step_count;
        exp_q.push_back(mk("sat1", 22, 28, 0, 0, 0, 16'hFFFF, HEADING_N, 1'b0, 1'b0));
        issue("sat1", 1'b1, 1'b0);
        finish_cmd();
        exp_q.push_back(mk("sat2", 22, 28, 0, 0, 0, 16'hFFFF, HEADING_N, 1'b0, 1'b0));
        issue("sat2", 1'b1, 1'b0);
        finish_cmd();

        exp_q.push_back(mk("rot5", 0, 0, 15, 21, 0, 16'hFFFF, HEADING_E, 1'b0, 1'b0));
        issue("rot5", 1'b0, 1'b1);
        finish_cmd();

        issue("rot_rst", 1'b0, 1'b1);
        repeat (8) begin @(posedge clk); #1; end
        check("rot_mid_motors", {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir}, 4'b1110);
        rst_n = 1'b0;
        #1;
        check("rot_rst_motors", {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir}, 4'b0000);
        check("rot_rst_state", {heading, busy, bump}, {HEADING_N, 1'b1, 1'b0});
        check("rot_rst_step", step_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_offer("post_rst");
        check("post_rst_heading", heading, HEADING_N);
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
